// File: rtl/mem_bus_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
package mem_bus_pkg;

  // Ownership state: nobody locked, or master 0 / master 1 holding a lock
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Master indices into the request/grant vectors
  localparam int M_PROC = 0;
  localparam int M_DMA  = 1;

  // Default bound on consecutive locked grants
  localparam int DEF_MAX_LOCK = 4;

  // Which masters may be granted in a given ownership state
  function automatic logic [1:0] allow_mask(input arb_state_t st);
    case (st)
      IDLE:    allow_mask = 2'b11;
      OWN0:    allow_mask = 2'b01;
      OWN1:    allow_mask = 2'b10;
      default: allow_mask = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: one-hot grant among eligible requesters,
// tie broken in favour of the master not granted most recently.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] allow,
  output logic [1:0] gnt
);

  logic [1:0] elig;

  assign elig = req & allow;

  // On a tie, the master that was not last granted wins
  always_comb begin
    gnt = elig;
    if (elig == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port synchronous memory between the processor
// core (master 0) and a DMA/debug loader (master 1), with bounded locking.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_lock,
  input  logic          m1_lock,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_LOCK);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LOCK - 1);

  arb_state_t    state_reg, state_next;
  logic          last_reg, last_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    rvalid_reg;
  logic [AW-1:0] addr_hold_reg;
  logic [DW-1:0] wdata_hold_reg;

  logic [1:0]    req_vec, we_vec, allow, gnt, rvalid_vec;
  logic          any_gnt, gnt_idx, sel_lock, sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign req_vec = {m1_req, m0_req};
  assign we_vec  = {m1_we, m0_we};

  // Nobody is eligible while reset is asserted
  assign allow = Resetn ? allow_mask(state_reg) : 2'b00;

  rr_pick2 u_pick (
    .req   (req_vec),
    .last  (last_reg),
    .allow (allow),
    .gnt   (gnt)
  );

  assign any_gnt   = |gnt;
  assign gnt_idx   = gnt[M_DMA];
  assign sel_lock  = gnt_idx ? m1_lock  : m0_lock;
  assign sel_we    = gnt_idx ? m1_we    : m0_we;
  assign sel_addr  = gnt_idx ? m1_addr  : m0_addr;
  assign sel_wdata = gnt_idx ? m1_wdata : m0_wdata;

  assign m0_gnt = gnt[M_PROC];
  assign m1_gnt = gnt[M_DMA];

  // Memory sees the granted master directly; otherwise the held mirror
  assign mem_addr  = any_gnt ? sel_addr  : addr_hold_reg;
  assign mem_wdata = any_gnt ? sel_wdata : wdata_hold_reg;
  assign mem_we    = any_gnt & sel_we;

  // A read in flight is dropped as soon as reset is asserted
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rvalid
      assign rvalid_vec[gi] = rvalid_reg[gi] & Resetn;
    end
  endgenerate

  assign m0_rvalid = rvalid_vec[M_PROC];
  assign m1_rvalid = rvalid_vec[M_DMA];
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

  // Next ownership state, lock counter and round-robin pointer
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    if (any_gnt) begin
      last_next = gnt_idx;
    end
    case (state_reg)
      IDLE: begin
        if (any_gnt && sel_lock) begin
          state_next = gnt_idx ? OWN1 : OWN0;
          cnt_next   = CW'(1);
        end
      end
      OWN0, OWN1: begin
        // Only the owner is eligible, so no grant means the owner let go
        if (any_gnt && sel_lock && (cnt_reg < CNT_LAST)) begin
          cnt_next = cnt_reg + CW'(1);
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, read-valid pipeline and memory input mirror
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_reg      <= IDLE;
      last_reg       <= 1'b1;
      cnt_reg        <= '0;
      rvalid_reg     <= 2'b00;
      addr_hold_reg  <= '0;
      wdata_hold_reg <= '0;
    end else begin
      state_reg  <= state_next;
      last_reg   <= last_next;
      cnt_reg    <= cnt_next;
      rvalid_reg <= gnt & ~we_vec;
      if (any_gnt) begin
        addr_hold_reg  <= sel_addr;
        wdata_hold_reg <= sel_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a read-data scoreboard.
module tb_mem_bus_arbiter;

  logic        Clock, Resetn;
  logic        m0_req, m1_req, m0_lock, m1_lock, m0_we, m1_we;
  logic [15:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  typedef struct {
    logic        m;
    logic [15:0] d;
  } sb_t;

  sb_t         sb_q[$];
  logic [15:0] mem_model [256];
  logic [15:0] ref_mem [256];
  logic [1:0]  pend_rv;
  logic [15:0] exp_addr_hold, exp_wdata_hold;
  int          n_cmp, n_fail;

  mem_bus_arbiter #(.AW(16), .DW(16), .MAX_LOCK(4)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .m0_req    (m0_req),
    .m1_req    (m1_req),
    .m0_lock   (m0_lock),
    .m1_lock   (m1_lock),
    .m0_we     (m0_we),
    .m1_we     (m1_we),
    .m0_addr   (m0_addr),
    .m1_addr   (m1_addr),
    .m0_wdata  (m0_wdata),
    .m1_wdata  (m1_wdata),
    .m0_gnt    (m0_gnt),
    .m1_gnt    (m1_gnt),
    .m0_rvalid (m0_rvalid),
    .m1_rvalid (m1_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Synchronous single-port memory, one-cycle registered read
  always @(posedge Clock) begin
    if (mem_we) mem_model[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem_model[mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic req, input logic lock, input logic we,
                       input logic [15:0] addr, input logic [15:0] wdata);
    if (k == 0) begin
      m0_req = req; m0_lock = lock; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_lock = lock; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  // One bus cycle: check outputs at negedge against expected grants, then advance
  task automatic tick(input logic eg0, input logic eg1, input string tag);
    logic [15:0] ea, ed;
    logic        ewe;
    logic [1:0]  erv;
    sb_t         sb;
    @(negedge Clock);
    if (eg0) begin
      ea = m0_addr; ed = m0_wdata; ewe = m0_we;
    end else if (eg1) begin
      ea = m1_addr; ed = m1_wdata; ewe = m1_we;
    end else begin
      ea = exp_addr_hold; ed = exp_wdata_hold; ewe = 1'b0;
    end
    chk({tag, ".m0_gnt"}, m0_gnt, eg0);
    chk({tag, ".m1_gnt"}, m1_gnt, eg1);
    chk({tag, ".mem_we"}, mem_we, ewe);
    chk({tag, ".mem_addr"}, mem_addr, ea);
    chk({tag, ".mem_wdata"}, mem_wdata, ed);
    erv = Resetn ? pend_rv : 2'b00;
    chk({tag, ".m0_rvalid"}, m0_rvalid, erv[0]);
    chk({tag, ".m1_rvalid"}, m1_rvalid, erv[1]);
    if (erv != 2'b00) begin
      if (sb_q.size() == 0) begin
        chk({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
        sb = sb_q.pop_front();
        chk({tag, ".rdata"}, sb.m ? m1_rdata : m0_rdata, sb.d);
      end
    end
    if (!Resetn) begin
      sb_q.delete();
      pend_rv        = 2'b00;
      exp_addr_hold  = 16'h0000;
      exp_wdata_hold = 16'h0000;
    end else begin
      pend_rv = {eg1 & ~m1_we, eg0 & ~m0_we};
      if (eg0 || eg1) begin
        if (ewe) ref_mem[ea[7:0]] = ed;
        else sb_q.push_back('{m: eg1, d: ref_mem[ea[7:0]]});
        exp_addr_hold  = ea;
        exp_wdata_hold = ed;
      end
    end
    $display("cycle %-8s g=%b%b we=%b addr=%h rv=%b%b", tag, m1_gnt, m0_gnt,
             mem_we, mem_addr, m1_rvalid, m0_rvalid);
    @(posedge Clock);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    pend_rv = 2'b00; exp_addr_hold = 16'h0000; exp_wdata_hold = 16'h0000;
    Resetn = 1'b0;
    drive(0, 1, 0, 1, 16'h0055, 16'h1234);
    drive(1, 0, 0, 0, 16'h0000, 16'h0000);
    @(posedge Clock);
    #1;
    // Reset: requests ignored, no write
    tick(0, 0, "rst0");
    tick(0, 0, "rst1");

    // Single master write then read back
    Resetn = 1'b1;
    drive(0, 1, 0, 1, 16'h0010, 16'h00A5);
    tick(1, 0, "s_wr");
    drive(0, 1, 0, 0, 16'h0010, 16'h0000);
    tick(1, 0, "s_rd");
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    tick(0, 0, "s_rv");

    // Tie straight after reset goes to master 0
    Resetn = 1'b0;
    tick(0, 0, "t_rst");
    Resetn = 1'b1;
    drive(0, 1, 0, 0, 16'h0010, 16'h0000);
    drive(1, 1, 0, 0, 16'h0010, 16'h0000);
    tick(1, 0, "t_c0");
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    tick(0, 1, "t_c1");
    drive(1, 0, 0, 0, 16'h0000, 16'h0000);
    tick(0, 0, "t_c2");

    // Master 1 locked sequence of three accesses while master 0 waits
    drive(0, 1, 0, 0, 16'h0010, 16'h0000);
    tick(1, 0, "l_a0");
    drive(0, 1, 0, 0, 16'h0021, 16'h0000);
    drive(1, 1, 1, 1, 16'h0020, 16'h1111);
    tick(0, 1, "l_a1");
    drive(1, 1, 1, 1, 16'h0021, 16'h2222);
    tick(0, 1, "l_a2");
    drive(1, 1, 0, 1, 16'h0022, 16'h3333);
    tick(0, 1, "l_a3");
    drive(1, 0, 0, 0, 16'h0000, 16'h0000);
    tick(1, 0, "l_a4");
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    tick(0, 0, "l_a5");

    // Starvation bound: master 0 locks forever, forced out after 4 grants
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 1, 16'h0030 + 16'(i), 16'h3000 + 16'(i));
      if (i == 1) drive(1, 1, 0, 0, 16'h0030, 16'h0000);
      tick(1, 0, $sformatf("st%0d", i));
    end
    drive(0, 1, 1, 1, 16'h0034, 16'h3004);
    tick(0, 1, "st_m1");
    drive(1, 0, 0, 0, 16'h0000, 16'h0000);
    tick(1, 0, "st_re");

    // Reset in the cycle after a locked read grant
    drive(0, 1, 1, 0, 16'h0031, 16'h0000);
    tick(1, 0, "r_rd");
    Resetn = 1'b0;
    drive(0, 1, 1, 1, 16'h0055, 16'hDEAD);
    tick(0, 0, "r_rst");
    Resetn = 1'b1;
    drive(0, 1, 0, 0, 16'h0030, 16'h0000);
    drive(1, 1, 0, 0, 16'h0031, 16'h0000);
    tick(1, 0, "r_tie");
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    tick(0, 1, "r_m1");
    drive(1, 0, 0, 0, 16'h0000, 16'h0000);
    tick(0, 0, "r_end");

    // Lock abandoned by dropping request; other master gets in next cycle
    drive(0, 1, 1, 1, 16'h0040, 16'h4444);
    tick(1, 0, "ab0");
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    drive(1, 1, 0, 1, 16'h0041, 16'h5555);
    tick(0, 0, "ab1");
    tick(0, 1, "ab2");
    drive(1, 1, 0, 0, 16'h0040, 16'h0000);
    tick(0, 1, "ab3");
    drive(1, 0, 0, 0, 16'h0000, 16'h0000);
    tick(0, 0, "ab4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
